// File: rtl/id_ex_stage_if.sv
// Signal bundle between the IF/ID register, the register file read ports,
// the writeback port, and the execute stage around id_ex_stage.
interface id_ex_stage_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        stall;
    logic        ex_valid;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_imm;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic [31:0] ex_pc_plus4;
    logic        ex_illegal;

    modport master (
        output id_valid, id_instr, id_pc_plus4, flush, rd0, rd1, wb_we, wb_wa, wb_wd,
        input  ra0, ra1, stall, ex_valid, ex_alu_op, ex_alu_src, ex_op_a, ex_op_b, ex_imm,
               ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_pc_plus4,
               ex_illegal
    );

    modport slave (
        input  id_valid, id_instr, id_pc_plus4, flush, rd0, rd1, wb_we, wb_wa, wb_wd,
        output ra0, ra1, stall, ex_valid, ex_alu_op, ex_alu_src, ex_op_a, ex_op_b, ex_imm,
               ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_pc_plus4,
               ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register: control decode, writeback bypass,
// load-use hazard detection and bubble insertion on flush/stall/illegal.
module id_ex_stage (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic        valid;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic [31:0] pc_plus4;
        logic        illegal;
    } ex_t;

    ex_t ex_d;
    ex_t ex_q;

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [2:0]  alu_op_s;
    logic        alu_src_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        branch_s;
    logic        reg_write_s;
    logic [4:0]  dest_s;
    logic        legal_s;
    logic        reads_rt_s;
    logic        stall_s;
    logic [31:0] op_a_s;
    logic [31:0] op_b_s;

    assign opcode_s = bus.id_instr[31:26];
    assign rs_s     = bus.id_instr[25:21];
    assign rt_s     = bus.id_instr[20:16];
    assign rd_s     = bus.id_instr[15:11];
    assign funct_s  = bus.id_instr[5:0];
    assign bus.ra0  = rs_s;
    assign bus.ra1  = rt_s;

    // Opcode/funct decode into control bits.
    always_comb begin
        alu_op_s    = 3'd0;
        alu_src_s   = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        branch_s    = 1'b0;
        reg_write_s = 1'b0;
        dest_s      = 5'd0;
        legal_s     = 1'b0;
        reads_rt_s  = 1'b0;
        case (opcode_s)
            6'h00: begin
                reads_rt_s  = 1'b1;
                dest_s      = rd_s;
                reg_write_s = 1'b1;
                legal_s     = 1'b1;
                case (funct_s)
                    6'h20:   alu_op_s = 3'd0;
                    6'h22:   alu_op_s = 3'd1;
                    6'h24:   alu_op_s = 3'd2;
                    6'h25:   alu_op_s = 3'd3;
                    6'h2A:   alu_op_s = 3'd4;
                    default: legal_s  = 1'b0;
                endcase
            end
            6'h23: begin
                alu_src_s   = 1'b1;
                mem_read_s  = 1'b1;
                dest_s      = rt_s;
                reg_write_s = 1'b1;
                legal_s     = 1'b1;
            end
            6'h2B: begin
                alu_src_s   = 1'b1;
                mem_write_s = 1'b1;
                reads_rt_s  = 1'b1;
                legal_s     = 1'b1;
            end
            6'h08: begin
                alu_src_s   = 1'b1;
                dest_s      = rt_s;
                reg_write_s = 1'b1;
                legal_s     = 1'b1;
            end
            6'h04: begin
                alu_op_s   = 3'd1;
                branch_s   = 1'b1;
                reads_rt_s = 1'b1;
                legal_s    = 1'b1;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Load-use: the load in EX cannot forward in time, so hold decode one cycle.
    assign stall_s = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.dest != 5'd0) &
                     ((ex_q.dest == rs_s) | ((ex_q.dest == rt_s) & reads_rt_s));
    assign bus.stall = stall_s;

    // Operand fetch: $0 reads as zero, otherwise same-cycle writeback wins over the RF.
    always_comb begin
        if (rs_s == 5'd0) begin
            op_a_s = 32'd0;
        end else if (bus.wb_we && (bus.wb_wa == rs_s)) begin
            op_a_s = bus.wb_wd;
        end else begin
            op_a_s = bus.rd0;
        end
        if (rt_s == 5'd0) begin
            op_b_s = 32'd0;
        end else if (bus.wb_we && (bus.wb_wa == rt_s)) begin
            op_b_s = bus.wb_wd;
        end else begin
            op_b_s = bus.rd1;
        end
    end

    // Next ID/EX contents: bubble unless a legal, valid, unstalled, unflushed instruction.
    always_comb begin
        ex_d = '0;
        if (!bus.flush && !stall_s && bus.id_valid) begin
            if (legal_s) begin
                ex_d.valid     = 1'b1;
                ex_d.alu_op    = alu_op_s;
                ex_d.alu_src   = alu_src_s;
                ex_d.op_a      = op_a_s;
                ex_d.op_b      = op_b_s;
                ex_d.imm       = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
                ex_d.dest      = dest_s;
                ex_d.reg_write = reg_write_s & (dest_s != 5'd0);
                ex_d.mem_read  = mem_read_s;
                ex_d.mem_write = mem_write_s;
                ex_d.branch    = branch_s;
                ex_d.pc_plus4  = bus.id_pc_plus4;
            end else begin
                ex_d.illegal = 1'b1;
            end
        end else begin
            ex_d.valid = 1'b0;
        end
    end

    // ID/EX register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_alu_op    = ex_q.alu_op;
    assign bus.ex_alu_src   = ex_q.alu_src;
    assign bus.ex_op_a      = ex_q.op_a;
    assign bus.ex_op_b      = ex_q.op_b;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_dest      = ex_q.dest;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_pc_plus4  = ex_q.pc_plus4;
    assign bus.ex_illegal   = ex_q.illegal;
endmodule
